bcm_multi: RTL

Multi-channel, parametrised successor to the single-channel binary-weighted PWM driver. It generates CHANNELS independent outputs from a shared frame counter. Each channel runs in either binary-code-modulation (BCM) mode or conventional compare PWM mode. Duty values are double-buffered, so updates take effect only at frame boundaries. The block sits between the register/LED-control logic and the output pins, and signals each completed frame with a one-cycle `done` pulse.

---
 rtl/bcm_multi.sv | 110 +++++++++++
 1 files changed

// File: rtl/bcm_multi.sv
// Multi-channel BCM / compare-PWM driver sharing one frame counter.
// Duty and mode are double-buffered and take effect only at frame boundaries.
module bcm_multi #(
    parameter int NO_BITS  = 8,
    parameter int CHANNELS = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         go,
    input  logic                         load,
    input  logic [CHANNELS*NO_BITS-1:0]  duty_in,
    input  logic [CHANNELS-1:0]          mode_in,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS-1:0]          out
);

    // state  | meaning
    // S_IDLE | counter parked at 0, outputs low, waiting for go
    // S_RUN  | counter sweeping 0..MAX, outputs modulated from active duty
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam int IW = (NO_BITS > 1) ? $clog2(NO_BITS) : 1;
    localparam logic [NO_BITS-1:0] MAX = '1;

    state_t                        r_state;
    logic [NO_BITS-1:0]            r_cnt;
    logic [CHANNELS*NO_BITS-1:0]   r_shadow_duty;
    logic [CHANNELS-1:0]           r_shadow_mode;
    logic [CHANNELS*NO_BITS-1:0]   r_active_duty;
    logic [CHANNELS-1:0]           r_active_mode;
    logic                          r_pending;
    logic [CHANNELS-1:0]           r_out;
    logic                          r_done;

    logic                          w_boundary;
    logic [IW-1:0]                 w_msb;
    logic [NO_BITS-1:0]            w_d;
    logic [CHANNELS-1:0]           w_out_next;

    assign w_boundary = go && ((r_state == S_IDLE) || (r_cnt == MAX));

    // BCM slot selection: the highest set bit of cnt picks which duty bit is shown.
    always_comb begin
        w_msb = '0;
        for (int b = 0; b < NO_BITS; b++) begin
            if (r_cnt[b]) w_msb = IW'(b);
        end
    end

    always_comb begin
        w_out_next = '0;
        w_d        = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_d = r_active_duty[c*NO_BITS +: NO_BITS];
            if (r_active_mode[c])
                w_out_next[c] = (r_cnt < w_d);
            else
                w_out_next[c] = (r_cnt != '0) && w_d[w_msb];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_shadow_duty <= '0;
            r_shadow_mode <= '0;
            r_active_duty <= '0;
            r_active_mode <= '0;
            r_pending     <= 1'b0;
            r_out         <= '0;
            r_done        <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_duty <= duty_in;
                r_shadow_mode <= mode_in;
            end
            // A boundary copies the pre-load shadow; a coincident load stays pending.
            if (w_boundary) begin
                r_active_duty <= r_shadow_duty;
                r_active_mode <= r_shadow_mode;
                r_pending     <= load;
            end else if (load) begin
                r_pending     <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_out  <= '0;
                    r_done <= 1'b0;
                    if (go) r_state <= S_RUN;
                end
                S_RUN: begin
                    r_out  <= w_out_next;
                    r_done <= (r_cnt == MAX);
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == MAX && !go) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign out  = r_out;

endmodule
